// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (for example
//   0xED set-LEDs or 0xFF reset) to the keyboard over the shared open-drain
//   PS/2 clock/data pair. The host inhibits the bus, presents the start bit
//   and releases the clock. From then on the keyboard supplies the bit
//   clock. The host changes data on each device falling edge and finally
//   checks the device ACK bit.
//
//   Optional feature: define PS2_TX_RETRY_EN to retry a failed frame (bad
//   ACK or timeout) up to MAX_RETRY extra times with the same byte. While
//   retries remain, the error pulses are suppressed.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tx_data[7:0] byte to send, captured when tx_valid && tx_ready
//   tx_valid     request to send tx_data
//   tx_ready     1 only in IDLE
//   busy         1 in every state except IDLE; the receive path ignores the
//                bus while it is set
//   done         1-cycle pulse: frame sent and ACK seen
//   ack_err      1-cycle pulse: ACK bit sampled high
//   timeout_err  1-cycle pulse: start or frame timer expired
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int START_TO_US = 15000,
  parameter int FRAME_TO_US = 2000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int START_CYC   = CYC_PER_US * START_TO_US;
  localparam int FRAME_CYC   = CYC_PER_US * FRAME_TO_US;
  localparam int TMR_W       = $clog2(START_CYC) + 1;

  // The timer counts down to zero, so loading N-1 gives exactly N cycles.
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] START_LOAD   = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] FRAME_LOAD   = TMR_W'(FRAME_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_XFER,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_nxt;
  logic [TMR_W-1:0] timer_q, timer_nxt;
  logic [3:0]       bit_cnt_q, bit_cnt_nxt;
  logic [9:0]       frame_q;       // {stop, parity, d7..d0}
  logic             capture;
  logic             done_nxt, ack_err_nxt, timeout_nxt;
  logic             fail_ack, fail_tmo;

  // ---------------------------------------------------------------------
  // Line synchronizers and falling-edge detection
  // ---------------------------------------------------------------------
  logic       clk_meta, clk_s;
  logic       data_meta, data_s;
  logic [1:0] hi_cnt;              // saturating count of sync'd clock-high cycles
  logic       fe;

  // Synchronizers reset high (idle bus) so no false edge appears after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
      hi_cnt    <= 2'd0;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_s     <= clk_meta;
      data_meta <= ps2_data_in;
      data_s    <= data_meta;
      if (!clk_s)
        hi_cnt <= 2'd0;
      else if (hi_cnt != 2'd2)
        hi_cnt <= hi_cnt + 2'd1;
    end
  end

  // A falling edge counts only if the clock was high for at least two
  // cycles before it, which rejects short glitches on the line.
  assign fe = !clk_s && (hi_cnt == 2'd2);

  // ---------------------------------------------------------------------
  // Retry bookkeeping (optional)
  // ---------------------------------------------------------------------
`ifdef PS2_TX_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0] retry_q, retry_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_q <= '0;
    else     retry_q <= retry_nxt;
  end
`else
  // MAX_RETRY has no effect without the retry feature.
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY > 0);
`endif

  // ---------------------------------------------------------------------
  // State register (with timer, bit counter and status pulses)
  // ---------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment, so all of them
  // update together from the values of the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= 4'd0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      timer_q     <= timer_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      done        <= done_nxt;
      ack_err     <= ack_err_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  // NOTE: frame_q is pure datapath and is only read after a capture has
  // loaded it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture)
      frame_q <= {1'b1, ~^tx_data, tx_data};
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal written below gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    timer_nxt   = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    bit_cnt_nxt = bit_cnt_q;
    capture     = 1'b0;
    done_nxt    = 1'b0;
    ack_err_nxt = 1'b0;
    timeout_nxt = 1'b0;
    fail_ack    = 1'b0;
    fail_tmo    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_nxt   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          capture     = 1'b1;
          timer_nxt   = INHIBIT_LOAD;
          bit_cnt_nxt = 4'd0;
          state_nxt   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_nxt   = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (timer_q == '0) begin
          timer_nxt = START_LOAD;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (timer_q == '0) begin
          fail_tmo = 1'b1;
        end else if (fe) begin
          // First device edge: d0 goes on the wire, frame timer starts.
          timer_nxt   = FRAME_LOAD;
          bit_cnt_nxt = 4'd0;
          state_nxt   = S_XFER;
        end
      end
      S_XFER: begin
        if (timer_q == '0) begin
          fail_tmo = 1'b1;
        end else if (fe) begin
          bit_cnt_nxt = bit_cnt_q + 4'd1;
          // The edge that moves past parity presents the stop bit.
          if (bit_cnt_q == 4'd8)
            state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (timer_q == '0) begin
          fail_tmo = 1'b1;
        end else if (fe) begin
          bit_cnt_nxt = 4'd10;
          if (data_s) fail_ack  = 1'b1;
          else        state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timer_q == '0) begin
          fail_tmo = 1'b1;
        end else if (clk_s && data_s) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (fail_ack || fail_tmo) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RTY_W'(MAX_RETRY)) begin
        retry_nxt   = retry_q + 1'b1;
        timer_nxt   = INHIBIT_LOAD;
        bit_cnt_nxt = 4'd0;
        state_nxt   = S_INHIBIT;
      end else begin
        ack_err_nxt = fail_ack;
        timeout_nxt = fail_tmo;
        state_nxt   = S_IDLE;
      end
`else
      ack_err_nxt = fail_ack;
      timeout_nxt = fail_tmo;
      state_nxt   = S_IDLE;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (decoded from state so reset releases the lines at once)
  // ---------------------------------------------------------------------
  always_comb begin
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        // Start bit appears in the last inhibit cycle, before clock release.
        ps2_data_oe = (timer_q == '0);
      end
      S_REQ:   ps2_data_oe = 1'b1;
      S_XFER:  ps2_data_oe = ~frame_q[bit_cnt_q];
      default: ;  // ACK and WAIT_IDLE leave both lines released
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  // 1 MHz system clock: one cycle per microsecond keeps the run short.
  localparam int CLK_HZ   = 1_000_000;
  localparam int INH_CYC  = 120;
  localparam int STA_CYC  = 15000;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_err, timeout_err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;

  always #500 clk = ~clk;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .INHIBIT_US (120),
    .START_TO_US(15000),
    .FRAME_TO_US(2000),
    .MAX_RETRY  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Monitor: pulse counts, inhibit length, clock-release and timeout times.
  int cyc = 0, n_done = 0, n_ack = 0, n_tmo = 0, n_inh = 0;
  int run = 0, inh_last = 0, rel_cyc = 0, tmo_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done)        n_done <= n_done + 1;
    if (ack_err)     n_ack  <= n_ack + 1;
    if (timeout_err) begin n_tmo <= n_tmo + 1; tmo_cyc <= cyc; end
    if (ps2_clk_oe) begin
      run <= run + 1;
      if (run == 0) n_inh <= n_inh + 1;
    end else begin
      if (run != 0) begin inh_last <= run; rel_cyc <= cyc; end
      run <= 0;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (no comparisons)
  // ---------------------------------------------------------------------
  task automatic wait_release(output int lat);
    lat = 0;
    while (ps2_clk_oe === 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Pulse tx_valid for one cycle; lat = cycles until the clock is released.
  task automatic start_tx(input logic [7:0] b, output int lat,
                          output logic rdy1, output logic busy1);
    int w;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rdy1     = tx_ready;
    busy1    = busy;
    wait_release(w);
    lat = 1 + w;
  endtask

  // Behavioural device: 40-cycle clock, samples data on the rising edge.
  // n pulses are generated (11 = full frame with ACK slot).
  task automatic dev_frame(input int n, input logic give_ack,
                           output logic [9:0] bits);
    bits = '0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < n && i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = ps2_data_in;
      repeat (10) @(negedge clk);
      if (i == 9 && n > 10 && give_ack) dev_data = 1'b0;
      repeat (10) @(negedge clk);
    end
    if (n > 10) begin
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
      repeat (5) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(output logic ok);
    int k = 0;
    while (tx_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    ok = (tx_ready === 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({done, ack_err, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {done, ack_err, timeout_err}); end
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL idle_after_reset ready %b clk_oe %b want 1 0", tx_ready, ps2_clk_oe); end
  endtask

  task automatic test_ed_frame;
    int lat, d0, a0, t0;
    logic rdy1, busy1, ok;
    logic [9:0] bits;
    d0 = n_done; a0 = n_ack; t0 = n_tmo;
    start_tx(8'hED, lat, rdy1, busy1);
    checks++; if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL ed_ready_drop ready %b busy %b want 0 1", rdy1, busy1); end
    checks++; if (lat !== INH_CYC + 1) begin errors++; $display("FAIL ed_release_latency got %0d want %0d", lat, INH_CYC + 1); end
    checks++; if (ps2_data_in !== 1'b0) begin errors++; $display("FAIL ed_start_bit got %b want 0", ps2_data_in); end
    dev_frame(11, 1'b1, bits);
    checks++; if (inh_last !== INH_CYC) begin errors++; $display("FAIL ed_inhibit_len got %0d want %0d", inh_last, INH_CYC); end
    checks++; if (bits !== {1'b1, 1'b1, 8'hED}) begin errors++; $display("FAIL ed_wire_bits got %b want %b", bits, {1'b1, 1'b1, 8'hED}); end
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ed_ready_return got %b want 1", ok); end
    checks++; if (n_done - d0 !== 1 || n_ack - a0 !== 0 || n_tmo - t0 !== 0) begin errors++; $display("FAIL ed_status done %0d ack %0d tmo %0d want 1 0 0", n_done - d0, n_ack - a0, n_tmo - t0); end
  endtask

  task automatic test_parity_01;
    int lat, d0;
    logic rdy1, busy1, ok;
    logic [9:0] bits;
    d0 = n_done;
    start_tx(8'h01, lat, rdy1, busy1);
    dev_frame(11, 1'b1, bits);
    checks++; if (bits[8] !== 1'b0) begin errors++; $display("FAIL p01_parity got %b want 0", bits[8]); end
    checks++; if (bits !== {1'b1, 1'b0, 8'h01}) begin errors++; $display("FAIL p01_wire_bits got %b want %b", bits, {1'b1, 1'b0, 8'h01}); end
    wait_ready(ok);
    checks++; if (ok !== 1'b1 || n_done - d0 !== 1) begin errors++; $display("FAIL p01_done ready %b done %0d want 1 1", ok, n_done - d0); end
  endtask

  task automatic test_ack_err;
    int lat, d0, a0, i0;
    logic rdy1, busy1, ok;
    logic [9:0] bits;
    d0 = n_done; a0 = n_ack; i0 = n_inh;
    start_tx(8'hFF, lat, rdy1, busy1);
    for (int a = 0; a < ATTEMPTS; a++) begin
      if (a > 0) wait_release(lat);
      dev_frame(11, 1'b0, bits);
      checks++; if (bits !== {1'b1, 1'b1, 8'hFF}) begin errors++; $display("FAIL ackerr_wire_bits try %0d got %b want %b", a, bits, {1'b1, 1'b1, 8'hFF}); end
    end
    wait_ready(ok);
    checks++; if (n_ack - a0 !== 1 || n_done - d0 !== 0) begin errors++; $display("FAIL ackerr_status ack %0d done %0d want 1 0", n_ack - a0, n_done - d0); end
    checks++; if (n_inh - i0 !== ATTEMPTS) begin errors++; $display("FAIL ackerr_inhibits got %0d want %0d", n_inh - i0, ATTEMPTS); end
  endtask

  task automatic test_timeout;
    int lat, k, t0, d0, i0, el;
    logic rdy1, busy1;
    t0 = n_tmo; d0 = n_done; i0 = n_inh;
    start_tx(8'hAA, lat, rdy1, busy1);
    k = 0;
    while (timeout_err !== 1'b1 && k < 50000) begin
      @(negedge clk);
      k++;
    end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_seen got %b want 1", timeout_err); end
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || tx_ready !== 1'b1) begin errors++; $display("FAIL tmo_release oe %b ready %b want 00 1", {ps2_clk_oe, ps2_data_oe}, tx_ready); end
    repeat (2) @(negedge clk);
    el = tmo_cyc - rel_cyc;
    checks++; if (el < STA_CYC - 1 || el > STA_CYC + 1) begin errors++; $display("FAIL tmo_time got %0d want %0d+/-1", el, STA_CYC); end
    checks++; if (n_tmo - t0 !== 1 || n_done - d0 !== 0 || n_inh - i0 !== ATTEMPTS) begin errors++; $display("FAIL tmo_status tmo %0d done %0d inh %0d want 1 0 %0d", n_tmo - t0, n_done - d0, n_inh - i0, ATTEMPTS); end
  endtask

  task automatic test_busy_ignore;
    int lat, d0, i0;
    logic rdy1, busy1, ok;
    logic [9:0] bits;
    d0 = n_done; i0 = n_inh;
    start_tx(8'hED, lat, rdy1, busy1);
    fork
      dev_frame(11, 1'b1, bits);
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    checks++; if (bits !== {1'b1, 1'b1, 8'hED}) begin errors++; $display("FAIL busy_wire_bits got %b want %b", bits, {1'b1, 1'b1, 8'hED}); end
    wait_ready(ok);
    repeat (300) @(negedge clk);
    checks++; if (n_inh - i0 !== 1 || n_done - d0 !== 1 || tx_ready !== 1'b1) begin errors++; $display("FAIL busy_ignored inh %0d done %0d ready %b want 1 1 1", n_inh - i0, n_done - d0, tx_ready); end
  endtask

  task automatic test_reset_mid;
    int lat, d0, a0, t0;
    logic rdy1, busy1, ok;
    logic [9:0] bits;
    start_tx(8'hA5, lat, rdy1, busy1);
    dev_frame(4, 1'b0, bits);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    d0 = n_done; a0 = n_ack; t0 = n_tmo;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL rstmid_release got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (n_done - d0 !== 0 || n_ack - a0 !== 0 || n_tmo - t0 !== 0) begin errors++; $display("FAIL rstmid_no_pulse done %0d ack %0d tmo %0d want 0 0 0", n_done - d0, n_ack - a0, n_tmo - t0); end
    d0 = n_done;
    start_tx(8'hF4, lat, rdy1, busy1);
    dev_frame(11, 1'b1, bits);
    checks++; if (bits !== {1'b1, 1'b0, 8'hF4}) begin errors++; $display("FAIL f4_wire_bits got %b want %b", bits, {1'b1, 1'b0, 8'hF4}); end
    wait_ready(ok);
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL f4_done got %0d want 1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_ed_frame();
    test_parity_01();
    test_ack_err();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
